// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary count, bouncing scan, breathe PWM and freeze.
// Breathe mode is compiled in only when LED_PATTERN_BREATHE_EN is defined.

module led_pattern_gen #(
  parameter int BANKS = 4,
  parameter int TAP   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  output logic [8*BANKS-1:0] leds,
  output logic               tick,
  output logic [1:0]         mode_active
);

  localparam int LW    = 8 * BANKS;
  localparam int POS_W = $clog2(LW);

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_FREEZE  = 2'd3
  } mode_e;

  logic [TAP-1:0]   presc_q, presc_d;
  logic             tick_q, tick_d;
  mode_e            mode_q, mode_d, mode_req;
  logic [7:0]       step_q, step_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [LW-1:0]    leds_q, leds_d;

`ifdef LED_PATTERN_BREATHE_EN
  logic [7:0] duty_q, duty_d;
  logic [7:0] pwm_lvl;

  // Short prescalers are zero-extended into the 8-bit PWM compare.
  generate
    if (TAP >= 8) begin : g_lvl_full
      assign pwm_lvl = presc_q[7:0];
    end else begin : g_lvl_ext
      assign pwm_lvl = {{(8-TAP){1'b0}}, presc_q};
    end
  endgenerate

  function automatic logic pwm_on(input logic [7:0] lvl, input logic [7:0] dty);
    return (lvl < dty);
  endfunction
`endif

  always_comb begin
    presc_d  = presc_q + TAP'(1);
    tick_d   = (presc_q == {TAP{1'b1}});
    mode_req = mode_e'(mode);
`ifndef LED_PATTERN_BREATHE_EN
    if (mode_req == MODE_BREATHE) mode_req = MODE_BIN;
`endif
    mode_d = mode_q;
    step_d = step_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
`ifdef LED_PATTERN_BREATHE_EN
    duty_d = duty_q;
`endif

    // A mode switch only restarts the pattern; it never advances on that tick.
    if (tick_q) begin
      if (mode_req != mode_q) begin
        mode_d = mode_req;
        step_d = 8'h00;
        pos_d  = '0;
        dir_d  = 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
        duty_d = 8'h00;
`endif
      end else begin
        case (mode_q)
          MODE_BIN: step_d = step_q + 8'd1;
          MODE_SCAN: begin
            if (!dir_q) begin
              if (pos_q == POS_W'(LW-1)) begin
                pos_d = POS_W'(LW-2);
                dir_d = 1'b1;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = POS_W'(1);
                dir_d = 1'b0;
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
`ifdef LED_PATTERN_BREATHE_EN
          MODE_BREATHE: begin
            if (!dir_q) begin
              if (duty_q == 8'hFF) begin
                duty_d = 8'hFE;
                dir_d  = 1'b1;
              end else begin
                duty_d = duty_q + 8'd1;
              end
            end else begin
              if (duty_q == 8'h00) begin
                duty_d = 8'h01;
                dir_d  = 1'b0;
              end else begin
                duty_d = duty_q - 8'd1;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  // Output register follows pattern state one clock later; freeze holds it.
  always_comb begin
    leds_d = leds_q;
    case (mode_q)
      MODE_BIN:     leds_d = {BANKS{step_q}};
      MODE_SCAN:    leds_d = LW'(1) << pos_q;
`ifdef LED_PATTERN_BREATHE_EN
      MODE_BREATHE: leds_d = {LW{pwm_on(pwm_lvl, duty_q)}};
`endif
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      mode_q  <= MODE_BIN;
      step_q  <= 8'h00;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      leds_q  <= '0;
`ifdef LED_PATTERN_BREATHE_EN
      duty_q  <= 8'h00;
`endif
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      leds_q  <= leds_d;
`ifdef LED_PATTERN_BREATHE_EN
      duty_q  <= duty_d;
`endif
    end
  end

  assign leds        = leds_q;
  assign tick        = tick_q;
  assign mode_active = mode_q;

endmodule
